nvram_ioctl_bridge: RTL and testbench

- Serves the HPS ioctl channel for the board's battery-backed high-score NVRAM.
- Save (upload): the block reads NVRAM bytes and returns them to the HPS on request.
- Restore (download): the block writes HPS bytes into NVRAM.
- Sits between hps_io and mylstar_board, runs in the clk_sys domain, and pauses the CPU through a req/ack handshake before it touches the RAM port.

---
 rtl/nvram_pkg.sv | 22 ++
 rtl/nvram_ioctl_bridge.sv | 142 ++++++++++++++
 tb/tb_nvram_ioctl_bridge.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM ioctl bridge.
// Holds the FSM and session-mode enums plus the default index and fill byte.
package nvram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    READY,
    RD_WAIT,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    UPLOAD,
    DOWNLOAD
  } mode_t;

  localparam logic [7:0] NV_INDEX_DEF = 8'd4;
  localparam logic [7:0] OOR_FILL     = 8'hFF;

endpackage

// File: rtl/nvram_ioctl_bridge.sv
// Bridges the HPS ioctl save/restore channel onto the NVRAM port.
// Ports: clk_sys/reset_n; ioctl_* HPS side; pause_req/ack CPU
// handshake; cpu_nv_we dirty tracking; ram_* NVRAM port; nv_dirty.
module nvram_ioctl_bridge
  import nvram_pkg::*;
#(
  parameter int         AW       = 8,
  parameter logic [7:0] NV_INDEX = NV_INDEX_DEF,
  parameter int         RD_LAT   = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  input  logic          cpu_nv_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [7:0]    ram_dout,
  output logic          nv_dirty
);

  state_t        r_state;
  state_t        w_state_nxt;
  mode_t         r_mode;
  logic          r_sess_q;
  logic          r_ack_clr;
  logic          r_oor;
  logic [1:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic          r_dirty;

  logic w_sess;
  logic w_oor;
  logic w_rd_go;
  logic w_wr_go;
  logic w_rd_done;
  logic w_dirty_clr;

  assign w_sess = (ioctl_upload | ioctl_download)
                && (ioctl_index == NV_INDEX);
  assign w_oor  = |ioctl_addr[24:AW];

  assign w_rd_go = (r_state == READY) && w_sess
                && (r_mode == UPLOAD) && ioctl_rd;
  assign w_wr_go = (r_state == READY) && w_sess
                && (r_mode == DOWNLOAD) && ioctl_wr
                && !w_oor;
  assign w_rd_done = (r_state == RD_WAIT) && w_sess
                  && (r_cnt == 2'd1);

  // Clear on the way into RELEASE so it drops with pause_req.
  assign w_dirty_clr = (w_state_nxt == RELEASE)
                    || (r_state == RELEASE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_sess && !r_sess_q) w_state_nxt = PAUSE;
      end
      PAUSE: begin
        // r_ack_clr rejects an ack left high by the last session.
        if (!w_sess) w_state_nxt = RELEASE;
        else if (pause_ack && r_ack_clr) w_state_nxt = READY;
      end
      READY: begin
        if (!w_sess) w_state_nxt = RELEASE;
        else if (w_rd_go) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (!w_sess) w_state_nxt = RELEASE;
        else if (w_rd_done) w_state_nxt = READY;
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_mode    <= NONE;
      r_sess_q  <= 1'b0;
      r_ack_clr <= 1'b0;
      r_oor     <= 1'b0;
      r_cnt     <= 2'd0;
      r_addr    <= '0;
      r_din     <= 8'h00;
      r_dirty   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sess_q <= w_sess;

      if (r_state == RELEASE) r_ack_clr <= 1'b0;
      else if (!pause_ack)    r_ack_clr <= 1'b1;

      if (r_state == IDLE && w_state_nxt == PAUSE)
        r_mode <= ioctl_upload ? UPLOAD : DOWNLOAD;
      else if (r_state == RELEASE)
        r_mode <= NONE;

      if (w_rd_go) begin
        r_cnt <= 2'(RD_LAT);
        r_oor <= w_oor;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end

      if (w_rd_go || w_wr_go) r_addr <= ioctl_addr[AW-1:0];

      if (w_rd_done) r_din <= r_oor ? OOR_FILL : ram_dout;

      if (w_dirty_clr) r_dirty <= 1'b0;
      else if (r_state == IDLE && cpu_nv_we) r_dirty <= 1'b1;
    end
  end

  assign pause_req  = (r_state == PAUSE) || (r_state == READY)
                   || (r_state == RD_WAIT);
  assign ioctl_wait = (r_state == PAUSE) || (r_state == RD_WAIT)
                   || w_rd_go;
  assign ram_re     = w_rd_go && !w_oor;
  assign ram_we     = w_wr_go;
  assign ram_addr   = (w_rd_go || w_wr_go) ? ioctl_addr[AW-1:0]
                                           : r_addr;
  assign ram_din    = w_wr_go ? ioctl_dout : 8'h00;
  assign ioctl_din  = r_din;
  assign nv_dirty   = r_dirty;

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Directed testbench for nvram_ioctl_bridge (AW=8, RD_LAT=1).
// Models a 1-cycle-latency NVRAM and checks handshake and data paths.
module tb_nvram_ioctl_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack = 1'b0;
  logic        cpu_nv_we = 1'b0;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_dout;
  logic        nv_dirty;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rd_q = 8'h00;

  always #5 clk_sys = ~clk_sys;

  nvram_ioctl_bridge #(
    .AW(8), .NV_INDEX(8'd4), .RD_LAT(1)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .pause_req(pause_req),
    .pause_ack(pause_ack), .cpu_nv_we(cpu_nv_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_re(ram_re),
    .ram_dout(ram_dout), .nv_dirty(nv_dirty)
  );

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) rd_q <= mem[ram_addr];
  end
  assign ram_dout = rd_q;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Opens a session; returns how many cycles ioctl_wait was high.
  task automatic open_session(input bit up, input int ack_dly,
                              output int wcnt);
    tick();
    ioctl_index    = 8'd4;
    ioctl_upload   = up;
    ioctl_download = !up;
    @(negedge clk_sys);
    tick();
    wcnt = 0;
    for (int k = 1; k < 40; k++) begin
      pause_ack = (k >= ack_dly + 1);
      @(negedge clk_sys);
      if (!ioctl_wait) break;
      wcnt++;
      tick();
    end
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] exp,
                         input int exp_re);
    int wc, rc;
    logic [7:0] a0;
    wc = 0; rc = 0; a0 = 8'h00;
    tick();
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      if (k == 0) a0 = ram_addr;
      if (ram_re) rc++;
      if (!ioctl_wait) break;
      wc++;
      tick();
      ioctl_rd = 1'b0;
    end
    n_tests++;
    if (wc !== 2) begin
      n_fail++;
      $display("FAIL rd_wait_cycles a=%h got %0d want 2", a, wc);
    end
    n_tests++;
    if (rc !== exp_re) begin
      n_fail++;
      $display("FAIL rd_ram_re a=%h got %0d want %0d", a, rc, exp_re);
    end
    n_tests++;
    if (ioctl_din !== exp) begin
      n_fail++;
      $display("FAIL rd_data a=%h got %h want %h", a, ioctl_din, exp);
    end
    if (exp_re == 1) begin
      n_tests++;
      if (a0 !== a[7:0]) begin
        n_fail++;
        $display("FAIL rd_addr got %h want %h", a0, a[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    n_tests++;
    if ({ioctl_din, ram_addr, ram_din} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h want 0",
               ioctl_din, ram_addr, ram_din);
    end
    n_tests++;
    if ({ioctl_wait, pause_req, nv_dirty, ram_we, ram_re} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000",
               {ioctl_wait, pause_req, nv_dirty, ram_we, ram_re});
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_upload();
    int wc;
    tick();
    cpu_nv_we = 1'b1;
    tick();
    cpu_nv_we = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (nv_dirty !== 1'b1) begin
      n_fail++;
      $display("FAIL dirty_set got %b want 1", nv_dirty);
    end
    open_session(1'b1, 5, wc);
    n_tests++;
    if (wc !== 6) begin
      n_fail++;
      $display("FAIL up_pause_wait got %0d want 6", wc);
    end
    n_tests++;
    if (pause_req !== 1'b1) begin
      n_fail++;
      $display("FAIL up_pause_req got %b want 1", pause_req);
    end
    do_read(25'h010, 8'hA5, 1);
    do_read(25'h02F, 8'hEC, 1);
    do_read(25'h100, 8'hFF, 0);
    tick();
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if ({pause_req, nv_dirty} !== 2'b11) begin
      n_fail++;
      $display("FAIL up_end_pre got %b want 11", {pause_req, nv_dirty});
    end
    tick();
    pause_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if ({pause_req, nv_dirty, ioctl_wait} !== 3'b000) begin
      n_fail++;
      $display("FAIL up_release got %b want 000",
               {pause_req, nv_dirty, ioctl_wait});
    end
  endtask

  task automatic test_download();
    int wc;
    logic [7:0] d;
    open_session(1'b0, 2, wc);
    n_tests++;
    if (wc !== 3) begin
      n_fail++;
      $display("FAIL dn_pause_wait got %0d want 3", wc);
    end
    for (int a = 0; a < 256; a++) begin
      d = 8'(a) ^ 8'h5A;
      tick();
      ioctl_rd = 1'b0;
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      @(negedge clk_sys);
      n_tests++;
      if ({ram_we, ioctl_wait, ram_addr, ram_din} !==
          {1'b1, 1'b0, 8'(a), d}) begin
        n_fail++;
        $display("FAIL dn_write a=%0d got we=%b w=%b %h %h want %h",
                 a, ram_we, ioctl_wait, ram_addr, ram_din, d);
      end
      tick();
      ioctl_wr = 1'b0;
      ioctl_rd = 1'b1;
      @(negedge clk_sys);
      n_tests++;
      if ({ram_we, ram_re, ioctl_wait} !== 3'b000) begin
        n_fail++;
        $display("FAIL dn_gap a=%0d got %b want 000",
                 a, {ram_we, ram_re, ioctl_wait});
      end
    end
    tick();
    ioctl_rd = 1'b0;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h1FF;
    ioctl_dout = 8'h00;
    @(negedge clk_sys);
    n_tests++;
    if ({ram_we, ioctl_wait} !== 2'b00) begin
      n_fail++;
      $display("FAIL dn_oor got %b want 00", {ram_we, ioctl_wait});
    end
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if ({mem[8'h00], mem[8'h10], mem[8'hFF]} !== 24'h5A4AA5) begin
      n_fail++;
      $display("FAIL dn_mem got %h %h %h want 5a 4a a5",
               mem[8'h00], mem[8'h10], mem[8'hFF]);
    end
    tick();
    ioctl_download = 1'b0;
    tick();
    pause_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (pause_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dn_release got %b want 0", pause_req);
    end
  endtask

  task automatic test_bad_index();
    tick();
    ioctl_index = 8'd0;
    pause_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ioctl_upload   = (k < 6);
      ioctl_download = (k >= 6);
      ioctl_rd = k[0];
      ioctl_wr = !k[0];
      ioctl_addr = 25'(k);
      @(negedge clk_sys);
      n_tests++;
      if ({pause_req, ioctl_wait, ram_we, ram_re} !== 4'b0) begin
        n_fail++;
        $display("FAIL bad_index k=%0d got %b want 0000",
                 k, {pause_req, ioctl_wait, ram_we, ram_re});
      end
      tick();
    end
    ioctl_upload = 1'b0;
    ioctl_download = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_wr = 1'b0;
    pause_ack = 1'b0;
    ioctl_index = 8'd4;
  endtask

  task automatic test_reset_mid();
    int wc;
    open_session(1'b1, 1, wc);
    tick();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h020;
    tick();
    #2;
    n_tests++;
    if (ioctl_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rdwait got %b want 1", ioctl_wait);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ioctl_wait, pause_req, ram_re, ram_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_async got %b want 0000",
               {ioctl_wait, pause_req, ram_re, ram_we});
    end
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    pause_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clk_sys);
    tick();
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    n_tests++;
    if (pause_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle got %b want 0", pause_req);
    end
    tick();
    @(negedge clk_sys);
    n_tests++;
    if ({pause_req, ioctl_wait} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_repause got %b want 11", {pause_req, ioctl_wait});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk_sys);
      n_tests++;
      if (ioctl_wait !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_hold k=%0d got %b want 1", k, ioctl_wait);
      end
    end
    tick();
    pause_ack = 1'b1;
    tick();
    @(negedge clk_sys);
    n_tests++;
    if ({pause_req, ioctl_wait} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_ready got %b want 10", {pause_req, ioctl_wait});
    end
    tick();
    ioctl_upload = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stale_ack();
    bit done;
    done = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk_sys);
      n_tests++;
      if (ioctl_wait !== 1'b1) begin
        n_fail++;
        $display("FAIL stale_hold k=%0d got %b want 1", k, ioctl_wait);
      end
    end
    tick();
    pause_ack = 1'b0;
    tick();
    pause_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!done || pause_req !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_exit got done=%b req=%b want 1 1",
               done, pause_req);
    end
    tick();
    ioctl_upload = 1'b0;
    tick();
    pause_ack = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[8'h10] = 8'hA5;
    test_reset();
    test_upload();
    test_download();
    test_bad_index();
    test_reset_mid();
    test_stale_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
